// File: rtl/alu_exec_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the ALU execution unit: default datapath width,
// ALUS operation codes, the FSM state encoding and a helper that tells
// whether an ALUS code names a supported operation.
// ---------------------------------------------------------------------------
package alu_exec_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_DIV  = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } aluState_e;

  // Any code outside this list completes as an illegal operation.
  function automatic logic aluIsKnown(input logic [3:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_MULT, ALU_DIV: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// ---------------------------------------------------------------------------
// mul_div_iter
// Unsigned iterative multiply / divide core working on operand magnitudes.
// One step per cycle while step_i is high; WIDTH steps complete an operation.
//   Multiply: shift-add, {hi,lo} ends holding the 2*WIDTH-bit product.
//   Divide  : restoring, lo ends holding the quotient, hi the remainder.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   load_i           capture operands and clear the step counter
//   isDiv_i          operation kind captured with load_i
//   magA_i, magB_i   operand magnitudes (A = multiplicand/dividend)
//   step_i           perform one iteration
//   hi_o, lo_o       working/result registers
//   lastStep_o       the step about to be taken is the final one
// ---------------------------------------------------------------------------
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             isDiv_i,
  input  logic [WIDTH-1:0] magA_i,
  input  logic [WIDTH-1:0] magB_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             lastStep_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q;
  logic             isDiv_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One iteration of either algorithm. For the divide, the remainder stays
  // below the divisor, so a borrow out of the WIDTH+1-bit trial subtraction
  // is exactly the "restore" condition. For the multiply, the carry of the
  // partial sum is shifted back into hi, so nothing is lost.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (isDiv_q) begin
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand capture and iteration. The multiply keeps the multiplier in lo
  // and the multiplicand in opnd; the divide keeps the dividend in lo and
  // the divisor in opnd.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      isDiv_q <= 1'b0;
      count_q <= '0;
    end else if (load_i) begin
      hi_q    <= '0;
      lo_q    <= isDiv_i ? magA_i : magB_i;
      opnd_q  <= isDiv_i ? magB_i : magA_i;
      isDiv_q <= isDiv_i;
      count_q <= '0;
    end else if (step_i) begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign lastStep_o = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Single-issue ALU execution unit. AND/OR/ADD/SUB/SLT complete in one cycle;
// MULT and DIV run on the iterative mul_div_iter core with sign handling here.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   Start           issue ALUS/A/B (ignored while an operation is in flight)
//   ALUS            operation select (codes in alu_exec_pkg)
//   A, B            two's-complement operands
//   Result, Zero    registered result and its zero flag
//   HI, LO          MULT product halves / DIV remainder and quotient
//   Busy            multi-cycle operation in progress
//   Done            one-cycle completion pulse
//   Illegal         one-cycle pulse with Done for an unknown ALUS code
// Build option:
//   ALU_EXEC_FAST_MULT_EN  when defined, MULT completes in a single cycle
//                          through a combinational multiplier; DIV is unchanged.
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [3:0]       ALUS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Illegal
);

  aluState_e        state_q;
  logic [WIDTH-1:0] Result_q, HI_q, LO_q;
  logic             Zero_q, Busy_q, Done_q, Illegal_q;
  logic             isDiv_q, negQ_q, negR_q, divZero_q;

  logic [WIDTH-1:0] simpleRes_d;
  logic [WIDTH-1:0] fixHi_d, fixLo_d;
  logic [2*WIDTH-1:0] prodMag, prodSigned;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH-1:0] dpHi, dpLo;
  logic             dpLast;
  logic             accept, dpLoad;

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  assign magA   = A[WIDTH-1] ? -A : A;
  assign magB   = B[WIDTH-1] ? -B : B;

  // A new operation may be issued from IDLE or in the DONE cycle.
  assign accept = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef ALU_EXEC_FAST_MULT_EN
  logic [2*WIDTH-1:0] fastProd;
  assign fastProd = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign dpLoad   = accept && (ALUS == ALU_DIV);
`else
  assign dpLoad   = accept && ((ALUS == ALU_DIV) || (ALUS == ALU_MULT));
`endif

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (dpLoad),
    .isDiv_i    (ALUS == ALU_DIV),
    .magA_i     (magA),
    .magB_i     (magB),
    .step_i     (state_q == ST_RUN),
    .hi_o       (dpHi),
    .lo_o       (dpLo),
    .lastStep_o (dpLast)
  );

  // Single-cycle operations. ADD/SUB simply wrap; SLT compares as signed.
  always_comb begin
    simpleRes_d = '0;
    case (ALUS)
      ALU_AND: simpleRes_d = A & B;
      ALU_OR:  simpleRes_d = A | B;
      ALU_ADD: simpleRes_d = A + B;
      ALU_SUB: simpleRes_d = A - B;
      ALU_SLT: simpleRes_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: simpleRes_d = '0;
    endcase
  end

  // Sign fix-up of the unsigned core result. The product sign and quotient
  // sign are A xor B; the remainder follows A. A zero divisor never ran the
  // core, so lo still holds |A| and HI gets A back.
  always_comb begin
    prodMag    = {dpHi, dpLo};
    prodSigned = negQ_q ? -prodMag : prodMag;
    fixHi_d    = prodSigned[2*WIDTH-1:WIDTH];
    fixLo_d    = prodSigned[WIDTH-1:0];
    if (isDiv_q) begin
      if (divZero_q) begin
        fixHi_d = negR_q ? -dpLo : dpLo;
        fixLo_d = '1;
      end else begin
        fixLo_d = negQ_q ? -dpLo : dpLo;
        fixHi_d = negR_q ? -dpHi : dpHi;
      end
    end
  end

  // Control FSM with registered outputs. Simple and illegal operations jump
  // straight to DONE; MULT/DIV go through RUN (skipped for a zero divisor)
  // and FIX. Reset wins over everything, including a simultaneous Start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      Result_q  <= '0;
      Zero_q    <= 1'b1;
      HI_q      <= '0;
      LO_q      <= '0;
      Busy_q    <= 1'b0;
      Done_q    <= 1'b0;
      Illegal_q <= 1'b0;
      isDiv_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      Done_q    <= 1'b0;
      Illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          Busy_q  <= 1'b0;
          if (Start) begin
            if (!aluIsKnown(ALUS)) begin
              Result_q  <= '0;
              Zero_q    <= 1'b1;
              Done_q    <= 1'b1;
              Illegal_q <= 1'b1;
              state_q   <= ST_DONE;
            end else if (ALUS == ALU_DIV) begin
              isDiv_q   <= 1'b1;
              negQ_q    <= A[WIDTH-1] ^ B[WIDTH-1];
              negR_q    <= A[WIDTH-1];
              divZero_q <= (B == '0);
              Busy_q    <= 1'b1;
              state_q   <= (B == '0) ? ST_FIX : ST_RUN;
            end else if (ALUS == ALU_MULT) begin
`ifdef ALU_EXEC_FAST_MULT_EN
              HI_q     <= fastProd[2*WIDTH-1:WIDTH];
              LO_q     <= fastProd[WIDTH-1:0];
              Result_q <= fastProd[WIDTH-1:0];
              Zero_q   <= (fastProd[WIDTH-1:0] == '0);
              Done_q   <= 1'b1;
              state_q  <= ST_DONE;
`else
              isDiv_q   <= 1'b0;
              negQ_q    <= A[WIDTH-1] ^ B[WIDTH-1];
              negR_q    <= A[WIDTH-1];
              divZero_q <= 1'b0;
              Busy_q    <= 1'b1;
              state_q   <= ST_RUN;
`endif
            end else begin
              Result_q <= simpleRes_d;
              Zero_q   <= (simpleRes_d == '0);
              Done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (dpLast) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          HI_q     <= fixHi_d;
          LO_q     <= fixLo_d;
          Result_q <= fixLo_d;
          Zero_q   <= (fixLo_d == '0);
          Busy_q   <= 1'b0;
          Done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Result  = Result_q;
  assign Zero    = Zero_q;
  assign HI      = HI_q;
  assign LO      = LO_q;
  assign Busy    = Busy_q;
  assign Done    = Done_q;
  assign Illegal = Illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit (WIDTH=32). A latency-based model
// computes every operation with plain signed arithmetic and is compared with
// the DUT outputs on every falling edge; directed literal checks pin the
// model to hand-computed values. Honors ALU_EXEC_FAST_MULT_EN.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_BAD  = 4'b1111;

`ifdef ALU_EXEC_FAST_MULT_EN
  localparam int MULT_LAT = 1;
`else
  localparam int MULT_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   alus;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, illegal;

  int compared = 0;
  int failed   = 0;
  logic checkOn = 1'b0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .CLK     (clk),
    .RST     (rst),
    .Start   (start),
    .ALUS    (alus),
    .A       (a),
    .B       (b),
    .Result  (result),
    .Zero    (zero),
    .HI      (hi),
    .LO      (lo),
    .Busy    (busy),
    .Done    (done),
    .Illegal (illegal)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts, and reports a FAIL line on difference.
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Model state: the values the outputs must show, plus how many more edges
  // the operation in flight needs before its results appear.
  int           remain = 0;
  logic [W-1:0] mRes = '0, mHi = '0, mLo = '0;
  logic         mZero = 1'b1, mDone = 1'b0, mIll = 1'b0;
  logic [W-1:0] pRes, pHi, pLo;
  logic         pIll;

  // Work out an operation's architectural results and its latency in cycles
  // from Start to the Done cycle.
  task automatic predict(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    longint sx, sy, p;
    sx   = $signed(x);
    sy   = $signed(y);
    pIll = 1'b0;
    pHi  = mHi;
    pLo  = mLo;
    pRes = '0;
    lat  = 1;
    case (op)
      OP_AND:  pRes = x & y;
      OP_OR:   pRes = x | y;
      OP_ADD:  pRes = x + y;
      OP_SUB:  pRes = x - y;
      OP_SLT:  pRes = (sx < sy) ? 32'd1 : 32'd0;
      OP_MULT: begin
        p    = sx * sy;
        pHi  = p[2*W-1:W];
        pLo  = p[W-1:0];
        pRes = pLo;
        lat  = MULT_LAT;
      end
      OP_DIV: begin
        if (y == '0) begin
          pHi  = x;
          pLo  = '1;
          pRes = '1;
          lat  = 2;
        end else begin
          p    = sx / sy;
          pLo  = p[W-1:0];
          p    = sx % sy;
          pHi  = p[W-1:0];
          pRes = pLo;
          lat  = DIV_LAT;
        end
      end
      default: begin
        pRes = '0;
        pIll = 1'b1;
      end
    endcase
  endtask

  task automatic applyModel();
    mRes  = pRes;
    mZero = (pRes == '0);
    mHi   = pHi;
    mLo   = pLo;
    mDone = 1'b1;
    mIll  = pIll;
  endtask

  // Model advance on each rising edge: reset, finish the operation in
  // flight, or accept a new Start when nothing is in flight.
  always @(posedge clk) begin
    int lat;
    mDone = 1'b0;
    mIll  = 1'b0;
    if (rst) begin
      remain = 0;
      mRes   = '0;
      mZero  = 1'b1;
      mHi    = '0;
      mLo    = '0;
    end else if (remain > 0) begin
      remain--;
      if (remain == 0) applyModel();
    end else if (start) begin
      predict(alus, a, b, lat);
      remain = lat - 1;
      if (remain == 0) applyModel();
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("done",    W'(done),    W'(mDone));
      checkOutput("illegal", W'(illegal), W'(mIll));
      checkOutput("busy",    W'(busy),    W'(remain > 0));
      checkOutput("result",  result,      mRes);
      checkOutput("zero",    W'(zero),    W'(mZero));
      checkOutput("hi",      hi,          mHi);
      checkOutput("lo",      lo,          mLo);
    end
  end

  // Drive one Start pulse; returns on the falling edge after the accepting
  // edge, i.e. where a one-cycle operation shows Done.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    alus  = op;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for Done; n counts cycles from Start, 1 = next cycle.
  task automatic waitDone(input int limit, output int n);
    n = 1;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", W'(done), W'(1));
  endtask

  logic [W-1:0] tabA [5] = '{32'd123456789, 32'hFFFF_FC25, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF9C};
  logic [W-1:0] tabB [5] = '{32'hFFFF_FC25, 32'hFFFF_FFFF, 32'd1,          32'd3,          32'd0};
  logic [3:0]   tabOp[7] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MULT, OP_DIV};

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    alus  = OP_AND;
    a     = '0;
    b     = '0;
    @(negedge clk);
    @(negedge clk);
    checkOn = 1'b1;
    checkOutput("rstResult", result, 32'd0);
    checkOutput("rstZero",   W'(zero), W'(1));
    checkOutput("rstHi",     hi, 32'd0);
    checkOutput("rstLo",     lo, 32'd0);
    checkOutput("rstDone",   W'(done), W'(0));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(OP_ADD, 32'd7, 32'hFFFF_FFFD);
    checkOutput("addDone",   W'(done), W'(1));
    checkOutput("addResult", result, 32'd4);
    checkOutput("addZero",   W'(zero), W'(0));
    checkOutput("addBusy",   W'(busy), W'(0));
    applyStimulus(OP_SUB, 32'd5, 32'd5);
    checkOutput("subResult", result, 32'd0);
    checkOutput("subZero",   W'(zero), W'(1));
    applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    checkOutput("sltNegPos", result, 32'd1);
    applyStimulus(OP_SLT, 32'd1, 32'hFFFF_FFFF);
    checkOutput("sltPosNeg", result, 32'd0);
    applyStimulus(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    checkOutput("andResult", result, 32'h0000_F000);
    applyStimulus(OP_OR, 32'h0000_F0F0, 32'h0000_FF00);
    checkOutput("orResult", result, 32'h0000_FFF0);
    @(negedge clk);

    applyStimulus(OP_MULT, 32'hFFFF_FFFA, 32'd7);
    waitDone(60, n);
    checkOutput("multLatency", W'(n), W'(MULT_LAT));
    checkOutput("multHi", hi, 32'hFFFF_FFFF);
    checkOutput("multLo", lo, 32'hFFFF_FFD6);
    @(negedge clk);

    applyStimulus(OP_DIV, 32'hFFFF_FFEF, 32'd5);
    waitDone(60, n);
    checkOutput("divLatency", W'(n), W'(DIV_LAT));
    checkOutput("divLo", lo, 32'hFFFF_FFFD);
    checkOutput("divHi", hi, 32'hFFFF_FFFE);
    // Issued in the DONE cycle: back-to-back acceptance.
    applyStimulus(OP_DIV, 32'd9, 32'd0);
    waitDone(60, n);
    checkOutput("div0Latency", W'(n), W'(2));
    checkOutput("div0Lo", lo, 32'hFFFF_FFFF);
    checkOutput("div0Hi", hi, 32'd9);
    checkOutput("div0Result", result, 32'hFFFF_FFFF);
    applyStimulus(OP_BAD, 32'd1, 32'd2);
    checkOutput("badIllegal", W'(illegal), W'(1));
    checkOutput("badDone",    W'(done), W'(1));
    checkOutput("badResult",  result, 32'd0);
    checkOutput("badHi",      hi, 32'd9);
    checkOutput("badLo",      lo, 32'hFFFF_FFFF);
    @(negedge clk);

    applyStimulus(OP_MULT, MIN_NEG, 32'hFFFF_FFFF);
    waitDone(60, n);
    checkOutput("minMulHi", hi, 32'd0);
    checkOutput("minMulLo", lo, 32'h8000_0000);
    applyStimulus(OP_MULT, MIN_NEG, MIN_NEG);
    waitDone(60, n);
    checkOutput("minSqHi", hi, 32'h4000_0000);
    checkOutput("minSqLo", lo, 32'd0);
    applyStimulus(OP_DIV, MIN_NEG, 32'hFFFF_FFFF);
    waitDone(60, n);
    checkOutput("minDivLo", lo, 32'h8000_0000);
    checkOutput("minDivHi", hi, 32'd0);
    applyStimulus(OP_DIV, MIN_NEG, 32'd7);
    waitDone(60, n);
    checkOutput("minDiv7Lo", lo, 32'hEDB6_DB6E);
    checkOutput("minDiv7Hi", hi, 32'hFFFF_FFFE);
    @(negedge clk);

`ifndef ALU_EXEC_FAST_MULT_EN
    // Start while a MULT is busy must be dropped.
    applyStimulus(OP_MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    applyStimulus(OP_ADD, 32'd1, 32'd1);
    waitDone(60, n);
    checkOutput("busyMulResult", result, 32'd12);
    @(negedge clk);
`endif
    applyStimulus(OP_DIV, 32'd100, 32'd8);
    repeat (4) @(negedge clk);
    applyStimulus(OP_ADD, 32'd1, 32'd1);
    waitDone(60, n);
    checkOutput("busyDivLo", lo, 32'd12);
    checkOutput("busyDivHi", hi, 32'd4);
    @(negedge clk);

    // Reset in the middle of a DIV, together with a Start.
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst   = 1'b1;
    alus  = OP_ADD;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("abortBusy",   W'(busy), W'(0));
    checkOutput("abortDone",   W'(done), W'(0));
    checkOutput("abortResult", result, 32'd0);
    checkOutput("abortZero",   W'(zero), W'(1));
    checkOutput("abortHi",     hi, 32'd0);
    checkOutput("abortLo",     lo, 32'd0);
    repeat (40) @(negedge clk);

    foreach (tabA[i]) begin
      foreach (tabOp[j]) begin
        applyStimulus(tabOp[j], tabA[i], tabB[i]);
        waitDone(60, n);
      end
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
